// File: rtl/matrix_to_byte_if.sv
// Handshake and data bundle between the cipher core, matrix_to_byte and the byte sink.
// The master drives the column buses, done and byte_ready. The slave is the serializer.
interface matrix_to_byte_if;
   logic [31:0] I_bus0;
   logic [31:0] I_bus1;
   logic [31:0] I_bus2;
   logic [31:0] I_bus3;
   logic        done;
   logic        byte_ready;
   logic [7:0]  byte_out;
   logic        byte_valid;
   logic        blk_done;
   logic        busy;
   logic        overflow;

   modport master (
      output I_bus0, I_bus1, I_bus2, I_bus3, done, byte_ready,
      input  byte_out, byte_valid, blk_done, busy, overflow
   );

   modport slave (
      input  I_bus0, I_bus1, I_bus2, I_bus3, done, byte_ready,
      output byte_out, byte_valid, blk_done, busy, overflow
   );
endinterface

// File: rtl/matrix_to_byte.sv
// Serializes a 128-bit column-major cipher result into 16 bytes over valid/ready.
// A one-block pending buffer absorbs a result that arrives while a block is still draining.
//
// state | meaning
// IDLE  | nothing to send, byte_valid low, waiting for done
// SEND  | presenting sreg[127:120]; a transfer shifts sreg and advances cnt
module matrix_to_byte (
   input  logic              clk,
   input  logic              rst,
   matrix_to_byte_if.slave   bus
);

   typedef enum logic {IDLE, SEND} state_t;

   state_t       state;
   logic [127:0] sreg;
   logic [127:0] pbuf;
   logic [3:0]   cnt;
   logic         pend;

   logic [127:0] blk_in;
   logic         sending;
   logic         xfer;
   logic         last_xfer;

   // Column 0 lands in the top bits so byte 0 is the first to leave sreg.
   assign blk_in    = {bus.I_bus0, bus.I_bus1, bus.I_bus2, bus.I_bus3};
   assign sending   = (state == SEND);
   assign xfer      = sending & bus.byte_ready;
   assign last_xfer = xfer & (cnt == 4'd15);

   assign bus.byte_valid = sending;
   assign bus.byte_out   = sending ? sreg[127:120] : 8'h00;
   assign bus.blk_done   = last_xfer;
   assign bus.busy       = sending | pend;
   // A done landing on the last byte is always absorbed by the reload path.
   assign bus.overflow   = sending & bus.done & pend & ~last_xfer;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         sreg  <= '0;
         pbuf  <= '0;
         cnt   <= '0;
         pend  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.done) begin
                  sreg  <= blk_in;
                  cnt   <= '0;
                  state <= SEND;
               end
            end
            SEND: begin
               if (last_xfer) begin
                  cnt <= '0;
                  if (pend) begin
                     sreg <= pbuf;
                     if (bus.done) begin
                        pbuf <= blk_in;
                     end else begin
                        pend <= 1'b0;
                     end
                  end else if (bus.done) begin
                     sreg <= blk_in;
                  end else begin
                     sreg  <= '0;
                     state <= IDLE;
                  end
               end else begin
                  if (xfer) begin
                     sreg <= {sreg[119:0], 8'h00};
                     cnt  <= cnt + 4'd1;
                  end
                  if (bus.done && !pend) begin
                     pbuf <= blk_in;
                     pend <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matrix_to_byte.sv
// Scoreboard bench for matrix_to_byte: directed blocks push expected bytes into a queue,
// an independent monitor pops and compares on every accepted byte.
module tb_matrix_to_byte;

   typedef struct {
      logic [7:0] b;
      logic       last;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   matrix_to_byte_if bif ();

   matrix_to_byte dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   int   checks   = 0;
   int   failures = 0;
   exp_t q[$];

   int           d_off[$];
   logic [127:0] d_blk[$];
   bit           busy_h  [0:99];
   bit           valid_h [0:99];
   bit           blk_h   [0:99];
   bit           ovf_h   [0:99];

   // Expected byte streams, written out by hand in transmit order.
   localparam logic [127:0] S1_EXP = 128'h00_11_22_33_44_55_66_77_88_99_AA_BB_CC_DD_EE_FF;
   localparam logic [127:0] A5_EXP = {16{8'hA5}};
   localparam logic [127:0] S2_EXP = 128'h01_23_45_67_89_AB_CD_EF_FE_DC_BA_98_76_54_32_10;
   localparam logic [127:0] S3_EXP = 128'hC0_FF_EE_00_13_57_9B_DF_24_68_AC_E0_0F_1E_2D_3C;

   localparam logic [127:0] S1_BUS = {32'h00112233, 32'h44556677, 32'h8899AABB, 32'hCCDDEEFF};
   localparam logic [127:0] A5_BUS = {4{32'hA5A5A5A5}};
   localparam logic [127:0] C3_BUS = {4{32'h3C3C3C3C}};
   localparam logic [127:0] S2_BUS = {32'h01234567, 32'h89ABCDEF, 32'hFEDCBA98, 32'h76543210};
   localparam logic [127:0] S3_BUS = {32'hC0FFEE00, 32'h13579BDF, 32'h2468ACE0, 32'h0F1E2D3C};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_bus(input logic [127:0] v);
      bif.I_bus0 = v[127:96];
      bif.I_bus1 = v[95:64];
      bif.I_bus2 = v[63:32];
      bif.I_bus3 = v[31:0];
   endtask

   task automatic push_stream(input logic [127:0] s);
      exp_t e;
      for (int k = 0; k < 16; k++) begin
         e.b    = s[127-8*k -: 8];
         e.last = (k == 15);
         q.push_back(e);
      end
   endtask

   // Runs ncyc cycles (cycle 0 = N) with byte_ready high, pulsing done at each d_off
   // entry with its block, and records the observable status per cycle.
   task automatic play(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         bif.done = 1'b0;
         set_bus({4{32'hDEADDEAD}});
         for (int i = 0; i < d_off.size(); i++) begin
            if (d_off[i] == c) begin
               set_bus(d_blk[i]);
               bif.done = 1'b1;
            end
         end
         @(negedge clk);
         busy_h[c]  = bif.busy;
         valid_h[c] = bif.byte_valid;
         blk_h[c]   = bif.blk_done;
         ovf_h[c]   = bif.overflow;
         cyc();
      end
      bif.done = 1'b0;
      d_off.delete();
      d_blk.delete();
   endtask

   function automatic int gaps(input int from, input int to);
      int n = 0;
      for (int c = from; c <= to; c++) begin
         if (!(busy_h[c] && valid_h[c])) n++;
      end
      return n;
   endfunction

   function automatic int ovf_pulses(input int ncyc);
      int n = 0;
      for (int c = 0; c < ncyc; c++) begin
         if (ovf_h[c]) n++;
      end
      return n;
   endfunction

   // Scoreboard monitor
   logic       prev_stall = 1'b0;
   logic [7:0] prev_byte  = 8'h00;
   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && bif.byte_valid)
            chk("hold_under_backpressure", {24'h0, bif.byte_out}, {24'h0, prev_byte});
         if (bif.byte_valid && bif.byte_ready) begin
            if (q.size() == 0) begin
               chk("unexpected_byte", {24'h0, bif.byte_out}, 32'hFFFF_FFFF);
            end else begin
               e = q.pop_front();
               chk("byte_out", {24'h0, bif.byte_out}, {24'h0, e.b});
               chk("blk_done_at_transfer", {31'h0, bif.blk_done}, {31'h0, e.last});
            end
         end else if (bif.blk_done) begin
            chk("blk_done_without_transfer", 32'h1, 32'h0);
         end
         prev_stall <= bif.byte_valid & ~bif.byte_ready;
         prev_byte  <= bif.byte_out;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int i;
      bif.done       = 1'b0;
      bif.byte_ready = 1'b0;
      set_bus('0);

      // Reset state
      repeat (2) cyc();
      @(negedge clk);
      chk("rst_byte_out",   {24'h0, bif.byte_out}, 32'h0);
      chk("rst_byte_valid", {31'h0, bif.byte_valid}, 32'h0);
      chk("rst_busy",       {31'h0, bif.busy}, 32'h0);
      chk("rst_blk_done",   {31'h0, bif.blk_done}, 32'h0);
      chk("rst_overflow",   {31'h0, bif.overflow}, 32'h0);
      cyc();
      rst = 1'b0;
      bif.byte_ready = 1'b1;
      cyc();

      // Single block
      push_stream(S1_EXP);
      d_off.push_back(0); d_blk.push_back(S1_BUS);
      play(18);
      chk("t1_valid_N",      {31'h0, valid_h[0]}, 32'h0);
      chk("t1_valid_N1",     {31'h0, valid_h[1]}, 32'h1);
      chk("t1_gapless",      gaps(1, 16), 32'h0);
      chk("t1_blk_done_N15", {31'h0, blk_h[15]}, 32'h0);
      chk("t1_blk_done_N16", {31'h0, blk_h[16]}, 32'h1);
      chk("t1_valid_N17",    {31'h0, valid_h[17]}, 32'h0);
      chk("t1_busy_N17",     {31'h0, busy_h[17]}, 32'h0);

      // Backpressure, byte_ready pattern 1,0,0 repeating
      push_stream(S1_EXP);
      set_bus(S1_BUS);
      bif.done = 1'b1;
      cyc();
      bif.done = 1'b0;
      set_bus({4{32'hDEADDEAD}});
      i = 0;
      while (q.size() > 0 && i < 200) begin
         bif.byte_ready = (i % 3 == 0);
         cyc();
         i++;
      end
      chk("t2_drained_in_budget", {31'h0, (q.size() == 0)}, 32'h1);
      bif.byte_ready = 1'b1;
      repeat (2) cyc();
      @(negedge clk);
      chk("t2_idle_after", {31'h0, bif.busy}, 32'h0);
      cyc();

      // Pending buffer: second block at N+5
      push_stream(S1_EXP);
      push_stream(A5_EXP);
      d_off.push_back(0); d_blk.push_back(S1_BUS);
      d_off.push_back(5); d_blk.push_back(A5_BUS);
      play(34);
      chk("t3_busy_valid_N1_N32", gaps(1, 32), 32'h0);
      chk("t3_blk_done_N16",      {31'h0, blk_h[16]}, 32'h1);
      chk("t3_blk_done_N32",      {31'h0, blk_h[32]}, 32'h1);
      chk("t3_busy_N33",          {31'h0, busy_h[33]}, 32'h0);
      chk("t3_no_overflow",       ovf_pulses(34), 32'h0);

      // Overflow: third block at N+6 while pending is full
      push_stream(S1_EXP);
      push_stream(A5_EXP);
      d_off.push_back(0); d_blk.push_back(S1_BUS);
      d_off.push_back(3); d_blk.push_back(A5_BUS);
      d_off.push_back(6); d_blk.push_back(C3_BUS);
      play(34);
      chk("t4_overflow_count", ovf_pulses(34), 32'h1);
      chk("t4_overflow_N6",    {31'h0, ovf_h[6]}, 32'h1);
      chk("t4_busy_N33",       {31'h0, busy_h[33]}, 32'h0);

      // Done coincident with last byte, nothing pending
      push_stream(S2_EXP);
      push_stream(S3_EXP);
      d_off.push_back(0);  d_blk.push_back(S2_BUS);
      d_off.push_back(16); d_blk.push_back(S3_BUS);
      play(34);
      chk("t5a_gapless",     gaps(1, 32), 32'h0);
      chk("t5a_no_overflow", ovf_pulses(34), 32'h0);
      chk("t5a_busy_N33",    {31'h0, busy_h[33]}, 32'h0);

      // Done coincident with last byte, pending full
      push_stream(S1_EXP);
      push_stream(A5_EXP);
      push_stream(S3_EXP);
      d_off.push_back(0);  d_blk.push_back(S1_BUS);
      d_off.push_back(2);  d_blk.push_back(A5_BUS);
      d_off.push_back(16); d_blk.push_back(S3_BUS);
      play(50);
      chk("t5b_gapless",     gaps(1, 48), 32'h0);
      chk("t5b_no_overflow", ovf_pulses(50), 32'h0);
      chk("t5b_busy_N49",    {31'h0, busy_h[49]}, 32'h0);

      // Async reset after byte 7 with a block pending
      push_stream(S1_EXP);
      d_off.push_back(0); d_blk.push_back(S1_BUS);
      d_off.push_back(2); d_blk.push_back(A5_BUS);
      play(9);
      chk("t6_valid_before_rst", {31'h0, bif.byte_valid}, 32'h1);
      #2;
      rst = 1'b1;
      q.delete();
      #1;
      chk("t6_rst_byte_valid", {31'h0, bif.byte_valid}, 32'h0);
      chk("t6_rst_busy",       {31'h0, bif.busy}, 32'h0);
      chk("t6_rst_byte_out",   {24'h0, bif.byte_out}, 32'h0);
      chk("t6_rst_blk_done",   {31'h0, bif.blk_done}, 32'h0);
      repeat (2) cyc();
      rst = 1'b0;
      cyc();
      @(negedge clk);
      chk("t6_idle_after_rst", {31'h0, bif.busy}, 32'h0);
      cyc();
      push_stream(S2_EXP);
      d_off.push_back(0); d_blk.push_back(S2_BUS);
      play(18);
      chk("t6_valid_N1",      {31'h0, valid_h[1]}, 32'h1);
      chk("t6_blk_done_N16",  {31'h0, blk_h[16]}, 32'h1);
      chk("t6_busy_N17",      {31'h0, busy_h[17]}, 32'h0);

      chk("scoreboard_empty", q.size(), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/matrix_to_byte.md
# matrix_to_byte

Serializes a 128-bit cipher result, presented as four 32-bit column buses, into a 16-byte output stream with a valid/ready handshake. It sits at the output of the cipher core and is the transmit-side counterpart of the byte-to-matrix input path, using the same column-major byte ordering. A one-block pending buffer absorbs a new result that arrives while the previous block is still draining.

## Interface
- none: block size fixed at 128 bits / 16 bytes; no parameters.

- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- I_bus0  in  32  column 0 of result (bytes 0..3)
- I_bus1  in  32  column 1 (bytes 4..7)
- I_bus2  in  32  column 2 (bytes 8..11)
- I_bus3  in  32  column 3 (bytes 12..15)
- done  in  1  one-cycle pulse; I_bus0..3 valid in that cycle only
- byte_ready  in  1  downstream accepts byte_out this cycle
- byte_out  out  8  current output byte
- byte_valid  out  1  byte_out is valid
- blk_done  out  1  one-cycle pulse coincident with transfer of byte 15
- busy  out  1  high while sending or while a block is pending
- overflow  out  1  one-cycle pulse: block dropped because both buffers were full

## Operation
- Byte order: byte k = I_bus(k/4)[31-8*(k%4) -: 8]; I_bus0[31:24] is sent first, I_bus3[7:0] last.
- Storage: shift register sreg[127:0], byte counter cnt[3:0], pending buffer pbuf[127:0] with flag pend.
- States: IDLE, SEND.
  - IDLE, done=1: sreg <= {I_bus0,I_bus1,I_bus2,I_bus3}, cnt <= 0, transition to SEND.
  - SEND: byte_valid=1, byte_out=sreg[127:120]. Transfer = byte_valid & byte_ready. A transfer shifts sreg left by 8 and increments cnt.
  - SEND, transfer with cnt=15 (last byte): blk_done=1 this cycle. The next block is selected by priority:
    - pend=1: sreg <= pbuf, pend cleared. If done is also high, the buses go into pbuf and pend stays 1.
    - pend=0, done=1: sreg <= buses directly.
    - neither: go to IDLE.
    - In both reload cases cnt <= 0 and the state stays SEND.
  - SEND, not last transfer, done=1:
    - pend=0: pbuf <= buses, pend <= 1.
    - pend=1: new block discarded, overflow=1 for one cycle, pbuf unchanged.
- busy = (state==SEND) | pend.
- byte_valid is low in IDLE. byte_out is 8'h00 in IDLE.

## Timing
- Reset (async, immediate): state=IDLE, sreg=0, pbuf=0, cnt=0, pend=0. All outputs are 0: byte_out=8'h00, byte_valid, blk_done, busy and overflow all low. A reset mid-block discards both the current and the pending block.
- Latency: done in cycle N gives byte 0 valid in cycle N+1.
- With byte_ready held high, one byte transfers per cycle. Block occupies cycles N+1..N+16. blk_done pulses in N+16.
- Back-to-back blocks have no gap: byte 0 of the next block is valid in the cycle after byte 15 transfers.
- Backpressure: while byte_valid=1 and byte_ready=0, byte_out and cnt hold. byte_ready is ignored when byte_valid=0.
- done is sampled every cycle regardless of byte_ready. A done that coincides with the last-byte transfer never causes overflow.
- overflow and blk_done are registered-style single-cycle pulses. They are never asserted while in reset.

## Test plan
- Reset then single block: I_bus0..3 = 32'h00112233, 44556677, 8899AABB, CCDDEEFF, done pulse, byte_ready=1. Required: bytes 00,11,…,FF on 16 consecutive cycles starting at N+1; blk_done pulses at N+16; busy drops at N+17; byte_valid drops at N+17.
- Backpressure: same block, byte_ready toggled 1,0,0,1,… Required: each byte stays stable until accepted; sequence is unchanged; blk_done pulses only on the accept of FF.
- Pending buffer: second block (all 8'hA5) done at N+5. Required: pend set; A5×16 begins at N+17 with no idle cycle; busy stays high continuously through N+32.
- Overflow: third done (8'h3C block) while pend=1 and not on the last byte. Required: overflow pulses one cycle; only the first two blocks appear on byte_out.
- Simultaneous last byte + done, with pend=0: next block's byte 0 appears in the next cycle, no overflow. With pend=1: pbuf block is sent next, the new block is queued, no overflow.
- Async reset asserted mid-block (after byte 7) with pend=1: byte_valid, busy and byte_out are 0 immediately. After release, a fresh done sends a clean block starting from byte 0.
